// File: rtl/decode_skid_stage.sv
// ---------------------------------------------------------------------------
// decoder
//   Purely combinational field decoder for the 16-bit instruction format
//   {opcode[15:12], rd[11:8], rs1[7:4], rs2[3:0]}.
//   Ports: instr (in)  raw instruction
//          opcode/alu_op/rd/rs1/rs2/imm_sel/wb_sel and single-bit control
//          flags (out), imm (out) sign/shift-formatted 16-bit immediate.
// ---------------------------------------------------------------------------
module decoder (
   input  logic [15:0] instr,
   output logic [3:0]  opcode,
   output logic [3:0]  alu_op,
   output logic [3:0]  rd,
   output logic [3:0]  rs1,
   output logic [3:0]  rs2,
   output logic [1:0]  imm_sel,
   output logic [1:0]  wb_sel,
   output logic        reg_write,
   output logic        mem_read,
   output logic        mem_write,
   output logic        branch,
   output logic        jump,
   output logic        use_imm,
   output logic        halt,
   output logic        illegal,
   output logic [15:0] imm
);
   always_comb begin
      opcode    = instr[15:12];
      rd        = instr[11:8];
      rs1       = instr[7:4];
      rs2       = instr[3:0];
      alu_op    = 4'h0;
      imm_sel   = 2'd0;
      wb_sel    = 2'd0;
      reg_write = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      branch    = 1'b0;
      jump      = 1'b0;
      use_imm   = 1'b0;
      halt      = 1'b0;
      illegal   = 1'b0;
      case (instr[15:12])
         4'h0: ;                                                          // NOP
         4'h1: begin alu_op = 4'h1; reg_write = 1'b1; end                 // ADD
         4'h2: begin alu_op = 4'h2; reg_write = 1'b1; end                 // SUB
         4'h3: begin alu_op = 4'h3; reg_write = 1'b1; end                 // AND
         4'h4: begin alu_op = 4'h4; reg_write = 1'b1; end                 // OR
         4'h5: begin alu_op = 4'h5; reg_write = 1'b1; end                 // XOR
         4'h6: begin                                                      // ADDI
            alu_op = 4'h1; reg_write = 1'b1; use_imm = 1'b1; imm_sel = 2'd1;
         end
         4'h7: begin                                                      // LD
            alu_op = 4'h1; reg_write = 1'b1; mem_read = 1'b1; use_imm = 1'b1;
            imm_sel = 2'd1; wb_sel = 2'd1;
         end
         4'h8: begin                                                      // ST
            alu_op = 4'h1; mem_write = 1'b1; use_imm = 1'b1; imm_sel = 2'd1;
         end
         4'h9: begin alu_op = 4'h2; branch = 1'b1; imm_sel = 2'd2; end    // BEQ
         4'hA: begin                                                      // LUI
            reg_write = 1'b1; use_imm = 1'b1; imm_sel = 2'd3; wb_sel = 2'd3;
         end
         4'hB: begin                                                      // JMP (link)
            jump = 1'b1; reg_write = 1'b1; imm_sel = 2'd2; wb_sel = 2'd2;
         end
         4'hF: halt = 1'b1;
         default: illegal = 1'b1;
      endcase

      case (imm_sel)
         2'd1:    imm = {{12{instr[3]}}, instr[3:0]};
         2'd2:    imm = {{8{instr[7]}}, instr[7:0]};
         2'd3:    imm = {instr[7:0], 8'h00};
         default: imm = '0;
      endcase
   end
endmodule

// ---------------------------------------------------------------------------
// ctrl_encode
//   Packs decoded fields into the 33-bit control word:
//   [32] valid, [31:28] opcode, [27:24] alu_op, [23:20] rd, [19:16] rs1,
//   [15:12] rs2, [11:10] imm_sel, [9:8] wb_sel, [7] reg_write, [6] mem_read,
//   [5] mem_write, [4] branch, [3] jump, [2] use_imm, [1] halt, [0] illegal.
// ---------------------------------------------------------------------------
module ctrl_encode (
   input  logic [3:0]  opcode,
   input  logic [3:0]  alu_op,
   input  logic [3:0]  rd,
   input  logic [3:0]  rs1,
   input  logic [3:0]  rs2,
   input  logic [1:0]  imm_sel,
   input  logic [1:0]  wb_sel,
   input  logic        reg_write,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic        branch,
   input  logic        jump,
   input  logic        use_imm,
   input  logic        halt,
   input  logic        illegal,
   output logic [32:0] ctrl
);
   // Bit 32 set marks a real decoded instruction, so it never aliases a bubble.
   assign ctrl = {1'b1, opcode, alu_op, rd, rs1, rs2, imm_sel, wb_sel,
                  reg_write, mem_read, mem_write, branch, jump, use_imm,
                  halt, illegal};
endmodule

// ---------------------------------------------------------------------------
// decode_skid_stage
//   Registered decode stage between fetch and execute with ready/valid on
//   both sides, a one-entry skid buffer, synchronous flush and a saturating
//   back-pressure counter.
//   Ports: clk, rst (async, active high), flush (sync)
//          in_valid/in_ready/instr_in/pc_in      fetch side
//          out_valid/out_ready/control_signals_out/imm_out/pc_out  execute side
//          stall_cnt  cycles with out_valid && !out_ready (saturating)
// ---------------------------------------------------------------------------
module decode_skid_stage #(
   parameter int unsigned  PC_W     = 16,
   parameter logic [32:0]  NOP_CTRL = 33'h0,
   parameter int unsigned  CNT_W    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      instr_in,
   input  logic [PC_W-1:0]  pc_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [32:0]      control_signals_out,
   output logic [15:0]      imm_out,
   output logic [PC_W-1:0]  pc_out,
   output logic [CNT_W-1:0] stall_cnt
);
   typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [3:0]  d_opcode, d_alu_op, d_rd, d_rs1, d_rs2;
   logic [1:0]  d_imm_sel, d_wb_sel;
   logic        d_reg_write, d_mem_read, d_mem_write, d_branch;
   logic        d_jump, d_use_imm, d_halt, d_illegal;
   logic [15:0] dec_imm;
   logic [32:0] dec_ctrl;

   decoder u_decoder (
      .instr     (instr_in),
      .opcode    (d_opcode),
      .alu_op    (d_alu_op),
      .rd        (d_rd),
      .rs1       (d_rs1),
      .rs2       (d_rs2),
      .imm_sel   (d_imm_sel),
      .wb_sel    (d_wb_sel),
      .reg_write (d_reg_write),
      .mem_read  (d_mem_read),
      .mem_write (d_mem_write),
      .branch    (d_branch),
      .jump      (d_jump),
      .use_imm   (d_use_imm),
      .halt      (d_halt),
      .illegal   (d_illegal),
      .imm       (dec_imm)
   );

   ctrl_encode u_ctrl_encode (
      .opcode    (d_opcode),
      .alu_op    (d_alu_op),
      .rd        (d_rd),
      .rs1       (d_rs1),
      .rs2       (d_rs2),
      .imm_sel   (d_imm_sel),
      .wb_sel    (d_wb_sel),
      .reg_write (d_reg_write),
      .mem_read  (d_mem_read),
      .mem_write (d_mem_write),
      .branch    (d_branch),
      .jump      (d_jump),
      .use_imm   (d_use_imm),
      .halt      (d_halt),
      .illegal   (d_illegal),
      .ctrl      (dec_ctrl)
   );

   state_t           state_q, state_d;
   logic             in_ready_q, in_ready_d;
   logic [32:0]      ctrl_q, ctrl_d;
   logic [15:0]      imm_q, imm_d;
   logic [PC_W-1:0]  pc_q, pc_d;
   logic [32:0]      skid_ctrl_q, skid_ctrl_d;
   logic [15:0]      skid_imm_q, skid_imm_d;
   logic [PC_W-1:0]  skid_pc_q, skid_pc_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   logic accept, fire;

   assign out_valid           = (state_q != ST_EMPTY);
   assign in_ready            = in_ready_q;
   assign control_signals_out = ctrl_q;
   assign imm_out             = imm_q;
   assign pc_out              = pc_q;
   assign stall_cnt           = stall_cnt_q;

   assign accept = in_valid && in_ready_q;
   assign fire   = out_valid && out_ready;

   always_comb begin
      state_d     = state_q;
      ctrl_d      = ctrl_q;
      imm_d       = imm_q;
      pc_d        = pc_q;
      skid_ctrl_d = skid_ctrl_q;
      skid_imm_d  = skid_imm_q;
      skid_pc_d   = skid_pc_q;
      stall_cnt_d = stall_cnt_q;

      case (state_q)
         ST_EMPTY: begin
            if (accept) begin
               state_d = ST_ONE;
               ctrl_d  = dec_ctrl;
               imm_d   = dec_imm;
               pc_d    = pc_in;
            end
         end
         ST_ONE: begin
            if (accept && fire) begin
               ctrl_d = dec_ctrl;
               imm_d  = dec_imm;
               pc_d   = pc_in;
            end else if (accept) begin
               state_d     = ST_TWO;
               skid_ctrl_d = dec_ctrl;
               skid_imm_d  = dec_imm;
               skid_pc_d   = pc_in;
            end else if (fire) begin
               state_d = ST_EMPTY;
               ctrl_d  = NOP_CTRL;
            end
         end
         ST_TWO: begin
            if (fire) begin
               state_d     = ST_ONE;
               ctrl_d      = skid_ctrl_q;
               imm_d       = skid_imm_q;
               pc_d        = skid_pc_q;
               skid_ctrl_d = '0;
               skid_imm_d  = '0;
               skid_pc_d   = '0;
            end
         end
         default: state_d = ST_EMPTY;
      endcase

      // Flush overrides every transition; imm/pc keep their registered values
      // so any instruction loaded this cycle is dropped.
      if (flush) begin
         state_d     = ST_EMPTY;
         ctrl_d      = NOP_CTRL;
         imm_d       = imm_q;
         pc_d        = pc_q;
         skid_ctrl_d = '0;
         skid_imm_d  = '0;
         skid_pc_d   = '0;
      end

      // Registered ready derived from next state: no path from out_ready.
      in_ready_d = (state_d != ST_TWO);

      if (out_valid && !out_ready && (stall_cnt_q != CNT_MAX))
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_EMPTY;
         in_ready_q  <= 1'b1;
         ctrl_q      <= NOP_CTRL;
         imm_q       <= '0;
         pc_q        <= '0;
         skid_ctrl_q <= '0;
         skid_imm_q  <= '0;
         skid_pc_q   <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         ctrl_q      <= ctrl_d;
         imm_q       <= imm_d;
         pc_q        <= pc_d;
         skid_ctrl_q <= skid_ctrl_d;
         skid_imm_q  <= skid_imm_d;
         skid_pc_q   <= skid_pc_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end
endmodule

// File: doc/decode_skid_stage.md
# decode_skid_stage

Registered decode pipeline stage with a ready/valid handshake on both sides, a one-entry skid buffer, synchronous flush and a saturating stall counter. Sits between fetch and execute. Instantiates the existing `decoder` and `ctrl_encode` combinationally on `instr_in` and registers the 33-bit control word, 16-bit immediate and PC. Back-pressure from execute stalls fetch without dropping or duplicating instructions.

## Interface
- `PC_W`, 16, width of `pc_in`/`pc_out`.
- `NOP_CTRL`, 33'h0, control word driven while no valid instruction is presented (bubble).
- `CNT_W`, 8, width of `stall_cnt`.

- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `flush` in 1: synchronous; discards all held and incoming instructions.
- `in_valid` in 1: fetch presents `instr_in`/`pc_in`.
- `in_ready` out 1: stage accepts this cycle; registered.
- `instr_in` in 16: raw instruction.
- `pc_in` in PC_W: PC of `instr_in`.
- `out_valid` out 1: outputs hold a valid decoded instruction.
- `out_ready` in 1: execute consumes this cycle.
- `control_signals_out` out 33: encoded control word (`ctrl_encode` format).
- `imm_out` out 16: decoded immediate.
- `pc_out` out PC_W: PC of presented instruction.
- `stall_cnt` out CNT_W: saturating count of back-pressured cycles.

## Operation
- accept = `in_valid && in_ready`; fire = `out_valid && out_ready`.
- Decode of `instr_in` is combinational; only decoded fields `{ctrl, imm, pc}` are stored (main register and skid register).
- States: EMPTY (`out_valid`=0), ONE (main valid, skid empty), TWO (main and skid valid).
- EMPTY: accept -> ONE, main <= decoded input; else stay.
- ONE: accept&fire -> ONE, main <= input; accept&!fire -> TWO, skid <= input; fire&!accept -> EMPTY; neither -> stay.
- TWO: fire -> ONE, main <= skid; else stay. No accept possible.
- `in_ready` = 1 in EMPTY/ONE, 0 in TWO (registered, from next state).
- `out_valid` = 1 in ONE/TWO.
- On every entry into EMPTY, `control_signals_out` <= `NOP_CTRL`; `imm_out`, `pc_out` hold last values.
- Flush: highest priority over all transitions. Next state EMPTY, `control_signals_out` <= `NOP_CTRL`, skid cleared, `in_ready` <= 1. An instruction accepted in the flush cycle is dropped; a fire in the flush cycle still counts as consumed by execute.
- `stall_cnt`: +1 each cycle with `out_valid && !out_ready`, saturates at 2^CNT_W-1, never wraps; unaffected by flush; cleared only by reset.
- Order preserved: skid entry is always younger than main.

## Timing
- Reset values: state EMPTY, `out_valid` 0, `in_ready` 1, `control_signals_out` `NOP_CTRL`, `imm_out` 0, `pc_out` 0, `stall_cnt` 0, skid cleared.
- Latency: accept at edge N -> `out_valid` and decoded fields visible after edge N (one cycle).
- Throughput: one instruction per cycle with `out_ready` held high; `in_ready` never drops in that case.
- `in_ready` falls the cycle after an accept with no fire from ONE; rises the cycle after fire from TWO.
- `in_ready` has no combinational path from `out_ready`; outputs have no combinational path from inputs.
- Reset mid-operation: all state reset immediately, both held instructions lost.

## Test plan
- Stream: `out_ready`=1, present instrs A,B,C on PCs 0x0000,0x0002,0x0004 back-to-back -> one output per cycle, 1-cycle latency, `pc_out` 0x0000/0x0002/0x0004, ctrl/imm match `decoder`+`ctrl_encode` model, `stall_cnt` 0.
- Back-pressure: `out_ready`=0, offer A,B,C -> A and B accepted, `in_ready`=0 from cycle after B, C held by fetch; raise `out_ready` -> A,B,C emerge in order, none lost or duplicated; `stall_cnt` equals stalled cycles.
- Flush in TWO: fill A,B, assert `flush` with C valid -> next cycle `out_valid`=0, `control_signals_out`=`NOP_CTRL`, `in_ready`=1, C not emitted; D afterwards appears with 1-cycle latency.
- Bubble: single instruction then `in_valid`=0 -> after fire `out_valid`=0, `control_signals_out`=`NOP_CTRL`, `pc_out`/`imm_out` keep last values.
- Saturation: CNT_W=4, hold `out_valid`=1, `out_ready`=0 for 20 cycles -> `stall_cnt` reaches 15 and stays 15.
- Async reset in TWO mid-cycle -> outputs go to reset values without a clock edge; restart stream behaves as first scenario.
